layer_compositor: RTL and testbench

Parametrised pixel compositor for the VGA path. It takes NUM_LAYERS palette-indexed layers per pixel, selects the highest-priority opaque layer, and looks its colour up in a shared, runtime-loadable palette RAM. A frame-synchronous fade engine then scales the colour and drives VGA_R/G/B. It sits between the sprite/background/HUD address generators and the VGA controller, and generalises the fixed-layer combinational mapper to N layers, loadable palettes and a fade mode.

---
 rtl/compositor_pkg.sv | 26 ++
 rtl/palette_ram.sv | 24 ++
 rtl/layer_compositor.sv | 195 +++++++++++++++++++
 tb/tb_layer_compositor.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/compositor_pkg.sv
// Shared types, constants and the channel-scaling helper for the layer compositor.
package compositor_pkg;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  typedef enum logic [1:0] {
    IDLE,
    FADE_OUT,
    HOLD,
    FADE_IN
  } fade_state_t;

  localparam logic [8:0] FADE_FULL = 9'd256;

  // 8x9-bit product; level 256 reproduces c exactly, level 0 gives black.
  function automatic logic [7:0] scale_channel(input logic [7:0] c, input logic [8:0] level);
    logic [16:0] prod;
    prod = {9'd0, c} * {8'd0, level};
    return 8'(prod >> 8);
  endfunction

endpackage

// File: rtl/palette_ram.sv
// Simple dual-port palette RAM: one write port, one synchronous read-first read port.
module palette_ram #(
  parameter int AW = 10
) (
  input  logic          Clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [23:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [23:0]   rdata
);

  logic [23:0] mem [2**AW];

  // NOTE: the array has no reset branch so it maps onto block RAM; contents
  // are defined only by writes.
  always_ff @(posedge Clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/layer_compositor.sv
// N-layer priority select, palette lookup and frame-synchronous fade for the VGA path.
module layer_compositor
  import compositor_pkg::*;
#(
  parameter int          NUM_LAYERS  = 8,
  parameter int          IDX_W       = 8,
  parameter int          PAL_AW      = 10,
  parameter logic [23:0] BACKDROP    = 24'h800080,
  parameter int          FADE_STEP   = 16,
  parameter int          FADE_DIV    = 2,
  parameter int          HOLD_FRAMES = 30
) (
  input  logic                         Clk,
  input  logic                         Reset_n,
  input  logic                         pix_valid_in,
  input  logic [NUM_LAYERS-1:0]        layer_en,
  input  logic [NUM_LAYERS*IDX_W-1:0]  layer_idx,
  input  logic [NUM_LAYERS*PAL_AW-1:0] layer_base,
  input  logic                         pal_we,
  input  logic [PAL_AW-1:0]            pal_waddr,
  input  logic [23:0]                  pal_wdata,
  input  logic                         frame_start,
  input  logic                         fade_start,
  output logic                         fade_busy,
  output logic                         pix_valid_out,
  output logic [7:0]                   VGA_R,
  output logic [7:0]                   VGA_G,
  output logic [7:0]                   VGA_B
);

  localparam int          TICK_W     = $clog2(FADE_DIV + 1);
  localparam int          FRAME_W    = $clog2(HOLD_FRAMES + 1);
  localparam logic [TICK_W-1:0]  TICK_LAST  = TICK_W'(FADE_DIV - 1);
  localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(HOLD_FRAMES - 1);
  localparam logic [8:0]  STEP       = 9'(FADE_STEP);

  // Stage 1: priority select
  logic              sel_hit;
  logic [PAL_AW-1:0] sel_addr;
  logic              s1_valid, s1_backdrop;
  logic [PAL_AW-1:0] s1_addr;

  // NOTE: every always_comb output gets a default before any branch, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    sel_hit  = 1'b0;
    sel_addr = '0;
    // Walk from the lowest priority upward so layer 0 overwrites last and wins.
    for (int k = NUM_LAYERS - 1; k >= 0; k--) begin
      if (layer_en[k] && (layer_idx[k*IDX_W +: IDX_W] != '0)) begin
        sel_hit  = 1'b1;
        sel_addr = layer_base[k*PAL_AW +: PAL_AW] + PAL_AW'(layer_idx[k*IDX_W +: IDX_W]);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      s1_valid    <= 1'b0;
      s1_backdrop <= 1'b0;
      s1_addr     <= '0;
    end else begin
      s1_valid    <= pix_valid_in;
      s1_backdrop <= !sel_hit;
      s1_addr     <= sel_addr;
    end
  end

  // Stage 2: palette lookup
  logic        s2_valid, s2_backdrop;
  logic [23:0] pal_rdata;

  palette_ram #(.AW(PAL_AW)) u_palette (
    .Clk   (Clk),
    .we    (pal_we),
    .waddr (pal_waddr),
    .wdata (pal_wdata),
    .raddr (s1_addr),
    .rdata (pal_rdata)
  );

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      s2_valid    <= 1'b0;
      s2_backdrop <= 1'b0;
    end else begin
      s2_valid    <= s1_valid;
      s2_backdrop <= s1_backdrop;
    end
  end

  // Fade FSM
  fade_state_t        state, state_nxt;
  logic [8:0]         level, level_nxt;
  logic [TICK_W-1:0]  tick_cnt, tick_nxt;
  logic [FRAME_W-1:0] frame_cnt, frame_nxt;

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state     <= IDLE;
      level     <= FADE_FULL;
      tick_cnt  <= '0;
      frame_cnt <= '0;
    end else begin
      state     <= state_nxt;
      level     <= level_nxt;
      tick_cnt  <= tick_nxt;
      frame_cnt <= frame_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    level_nxt = level;
    tick_nxt  = tick_cnt;
    frame_nxt = frame_cnt;
    unique case (state)
      IDLE: begin
        // A frame_start coinciding with fade_start is deliberately not counted.
        if (fade_start) begin
          state_nxt = FADE_OUT;
          tick_nxt  = '0;
        end
      end
      FADE_OUT: begin
        if (frame_start) begin
          if (tick_cnt == TICK_LAST) begin
            tick_nxt = '0;
            if (level <= STEP) begin
              level_nxt = 9'd0;
              state_nxt = HOLD;
              frame_nxt = '0;
            end else begin
              level_nxt = level - STEP;
            end
          end else begin
            tick_nxt = tick_cnt + 1'b1;
          end
        end
      end
      HOLD: begin
        if (frame_start) begin
          if (frame_cnt == FRAME_LAST) begin
            state_nxt = FADE_IN;
            tick_nxt  = '0;
            frame_nxt = '0;
          end else begin
            frame_nxt = frame_cnt + 1'b1;
          end
        end
      end
      FADE_IN: begin
        if (frame_start) begin
          if (tick_cnt == TICK_LAST) begin
            tick_nxt = '0;
            if (level >= FADE_FULL - STEP) begin
              level_nxt = FADE_FULL;
              state_nxt = IDLE;
            end else begin
              level_nxt = level + STEP;
            end
          end else begin
            tick_nxt = tick_cnt + 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign fade_busy = (state != IDLE);

  // Stage 3: colour mux and fade
  rgb_t s2_color;
  assign s2_color = s2_backdrop ? rgb_t'(BACKDROP) : rgb_t'(pal_rdata);

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      pix_valid_out <= 1'b0;
      VGA_R         <= '0;
      VGA_G         <= '0;
      VGA_B         <= '0;
    end else begin
      pix_valid_out <= s2_valid;
      if (s2_valid) begin
        VGA_R <= scale_channel(s2_color.r, level);
        VGA_G <= scale_channel(s2_color.g, level);
        VGA_B <= scale_channel(s2_color.b, level);
      end
    end
  end

endmodule

// File: tb/tb_layer_compositor.sv
// Scoreboard bench for layer_compositor: directed pixels push expected colours, a monitor checks outputs.
module tb_layer_compositor;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        pix_valid_in;
  logic [7:0]  layer_en;
  logic [63:0] layer_idx;
  logic [79:0] layer_base;
  logic        pal_we;
  logic [9:0]  pal_waddr;
  logic [23:0] pal_wdata;
  logic        frame_start;
  logic        fade_start;
  logic        fade_busy;
  logic        pix_valid_out;
  logic [7:0]  VGA_R, VGA_G, VGA_B;

  int checks = 0;
  int errors = 0;

  logic [23:0] exp_q[$];
  string       name_q[$];

  layer_compositor #(
    .NUM_LAYERS (8),
    .IDX_W      (8),
    .PAL_AW     (10),
    .BACKDROP   (24'h800080),
    .FADE_STEP  (128),
    .FADE_DIV   (1),
    .HOLD_FRAMES(2)
  ) dut (
    .Clk          (Clk),
    .Reset_n      (Reset_n),
    .pix_valid_in (pix_valid_in),
    .layer_en     (layer_en),
    .layer_idx    (layer_idx),
    .layer_base   (layer_base),
    .pal_we       (pal_we),
    .pal_waddr    (pal_waddr),
    .pal_wdata    (pal_wdata),
    .frame_start  (frame_start),
    .fade_start   (fade_start),
    .fade_busy    (fade_busy),
    .pix_valid_out(pix_valid_out),
    .VGA_R        (VGA_R),
    .VGA_G        (VGA_G),
    .VGA_B        (VGA_B)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every presented pixel must match the oldest outstanding expectation.
  always @(negedge Clk) begin
    if (pix_valid_out === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pixel: got %h expected none", {VGA_R, VGA_G, VGA_B});
      end else begin
        check(name_q.pop_front(), {VGA_R, VGA_G, VGA_B}, exp_q.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic set_layer(input int k, input logic en, input logic [7:0] idx, input logic [9:0] base);
    layer_en[k]            = en;
    layer_idx[k*8 +: 8]    = idx;
    layer_base[k*10 +: 10] = base;
  endtask

  task automatic clear_layers();
    layer_en   = '0;
    layer_idx  = '0;
    layer_base = '0;
  endtask

  task automatic pal_write(input logic [9:0] addr, input logic [23:0] data);
    pal_we    = 1'b1;
    pal_waddr = addr;
    pal_wdata = data;
    step();
    pal_we    = 1'b0;
  endtask

  task automatic issue(input string name, input logic [23:0] exp);
    pix_valid_in = 1'b1;
    exp_q.push_back(exp);
    name_q.push_back(name);
    step();
    pix_valid_in = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 12 && exp_q.size() != 0; i++) step();
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
      exp_q.delete();
      name_q.delete();
    end
    step();
  endtask

  task automatic frame();
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    step();
    step();
  endtask

  initial begin
    Reset_n      = 1'b0;
    pix_valid_in = 1'b0;
    pal_we       = 1'b0;
    pal_waddr    = '0;
    pal_wdata    = '0;
    frame_start  = 1'b0;
    fade_start   = 1'b0;
    clear_layers();
    repeat (3) step();
    check("reset_rgb", {VGA_R, VGA_G, VGA_B}, 24'h000000);
    check("reset_valid", 24'(pix_valid_out), 24'd0);
    check("reset_busy", 24'(fade_busy), 24'd0);
    Reset_n = 1'b1;
    step();

    pal_write(10'h005, 24'h112233);
    pal_write(10'h105, 24'hAABBCC);
    pal_write(10'h007, 24'h00FF00);
    pal_write(10'h009, 24'h000001);
    pal_write(10'h001, 24'h123456);
    pal_write(10'h3FF, 24'h0A0B0C);
    pal_write(10'h020, 24'hFF8040);

    // Priority, then back-to-back with layer 0 disabled
    set_layer(0, 1'b1, 8'd5, 10'h000);
    set_layer(1, 1'b1, 8'd5, 10'h100);
    issue("priority_l0", 24'h112233);
    set_layer(0, 1'b0, 8'd5, 10'h000);
    issue("priority_l1", 24'hAABBCC);

    // Transparent index 0 on layer 0, disabled layer 1, opaque layer 2
    clear_layers();
    set_layer(0, 1'b1, 8'd0, 10'h000);
    set_layer(1, 1'b0, 8'd5, 10'h000);
    set_layer(2, 1'b1, 8'd7, 10'h000);
    issue("transparent", 24'h00FF00);
    clear_layers();
    layer_en = 8'hFF;
    issue("backdrop", 24'h800080);

    // Base offset wraps modulo 2^PAL_AW
    clear_layers();
    set_layer(3, 1'b1, 8'd2, 10'h3FF);
    issue("base_wrap", 24'h123456);
    wait_drain();
    check("gap_hold_rgb", {VGA_R, VGA_G, VGA_B}, 24'h123456);
    check("gap_valid", 24'(pix_valid_out), 24'd0);

    // Write to address 9 lands on the same edge as the first pixel's read
    clear_layers();
    set_layer(0, 1'b1, 8'd9, 10'h000);
    issue("collision_old", 24'h000001);
    pal_we    = 1'b1;
    pal_waddr = 10'h009;
    pal_wdata = 24'hFFFFFF;
    issue("collision_new", 24'hFFFFFF);
    pal_we    = 1'b0;
    wait_drain();

    // Full fade sequence on colour FF8040
    clear_layers();
    set_layer(0, 1'b1, 8'h20, 10'h000);
    fade_start = 1'b1;
    step();
    fade_start = 1'b0;
    check("busy_rise", 24'(fade_busy), 24'd1);
    frame(); issue("fade_out_128", 24'h7F4020); wait_drain();
    frame(); issue("fade_out_0", 24'h000000); wait_drain();
    frame();
    fade_start = 1'b1;
    step();
    fade_start = 1'b0;
    issue("hold_1", 24'h000000); wait_drain();
    check("busy_hold", 24'(fade_busy), 24'd1);
    frame(); issue("hold_2", 24'h000000); wait_drain();
    frame(); issue("fade_in_128", 24'h7F4020); wait_drain();
    check("busy_fade_in", 24'(fade_busy), 24'd1);
    frame(); issue("fade_in_256", 24'hFF8040); wait_drain();
    check("busy_fall", 24'(fade_busy), 24'd0);

    // Simultaneous fade_start/frame_start, then reset during HOLD
    fade_start  = 1'b1;
    frame_start = 1'b1;
    step();
    fade_start  = 1'b0;
    frame_start = 1'b0;
    step();
    frame(); issue("sync_start_128", 24'h7F4020); wait_drain();
    frame(); issue("sync_start_0", 24'h000000); wait_drain();
    check("busy_before_reset", 24'(fade_busy), 24'd1);
    Reset_n = 1'b0;
    step();
    Reset_n = 1'b1;
    check("mid_reset_busy", 24'(fade_busy), 24'd0);
    check("mid_reset_rgb", {VGA_R, VGA_G, VGA_B}, 24'h000000);
    check("mid_reset_valid", 24'(pix_valid_out), 24'd0);
    issue("post_reset_full", 24'hFF8040);
    wait_drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
